modulo_acondicionador_botones: RTL and testbench

// - Upstream stage of the game controller. Conditions the four raw board push-buttons for it.
// - Per button: 2-flop synchroniser, then a stability-counter debouncer.
// - A release-lockout FSM emits exactly one single-cycle, one-hot move pulse per press.
// - Outputs feed botonArriba/Abajo/Izquierda/Derecha of the game controller directly.

---
 rtl/modulo_acondicionador_botones_if.sv | 37 +++
 rtl/modulo_acondicionador_botones.sv | 159 +++++++++++++++
 tb/tb_modulo_acondicionador_botones.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/modulo_acondicionador_botones_if.sv
// Push-button bundle: raw board keys in, move pulses and
// debounced levels out toward the game controller.
interface modulo_acondicionador_botones_if;
  logic       botonArribaCrudo;
  logic       botonAbajoCrudo;
  logic       botonIzquierdaCrudo;
  logic       botonDerechaCrudo;
  logic       botonArriba;
  logic       botonAbajo;
  logic       botonIzquierda;
  logic       botonDerecha;
  logic [3:0] botonesEstables;

  modport master (
    output botonArribaCrudo,
    output botonAbajoCrudo,
    output botonIzquierdaCrudo,
    output botonDerechaCrudo,
    input  botonArriba,
    input  botonAbajo,
    input  botonIzquierda,
    input  botonDerecha,
    input  botonesEstables
  );

  modport slave (
    input  botonArribaCrudo,
    input  botonAbajoCrudo,
    input  botonIzquierdaCrudo,
    input  botonDerechaCrudo,
    output botonArriba,
    output botonAbajo,
    output botonIzquierda,
    output botonDerecha,
    output botonesEstables
  );
endinterface

// File: rtl/modulo_acondicionador_botones.sv
// Button conditioner: sync, debounce, one pulse per press.
// Define AUTO_REPETICION_EN to re-pulse a held button periodically.
module modulo_acondicionador_botones #(
  parameter int CICLOS_ESTABLE      = 500000,
  parameter int ANCHO_CONTADOR      = 20,
  parameter bit BOTONES_ACTIVO_BAJO = 1'b1,
  parameter int CICLOS_REPETICION   = 25000000,
  parameter int ANCHO_REPETICION    = 25
) (
  input  logic reloj,
  input  logic reinicio,
  modulo_acondicionador_botones_if.slave botones
);

  typedef enum logic {
    LIBRE,
    ESPERA_SUELTA
  } estado_t;

  localparam logic [3:0] REPOSO =
    {4{BOTONES_ACTIVO_BAJO}};
  localparam logic [ANCHO_CONTADOR-1:0] FIN_ESTABLE =
    ANCHO_CONTADOR'(CICLOS_ESTABLE - 1);

  logic [3:0] crudo;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] muestra;
  logic [3:0] estable;
  logic [3:0] bloqueado;
  logic [3:0] efectivo;
  logic [3:0] seleccion;
  logic [3:0] pulso;
  logic [3:0] pulso_sig;
  logic [1:0] llenado;
  logic [ANCHO_CONTADOR-1:0] contador [4];
  estado_t estado;
  estado_t estado_sig;

  assign crudo = {botones.botonDerechaCrudo,
                  botones.botonIzquierdaCrudo,
                  botones.botonAbajoCrudo,
                  botones.botonArribaCrudo};

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      s1 <= REPOSO;
      s2 <= REPOSO;
    end else begin
      s1 <= crudo;
      s2 <= s1;
    end
  end

  assign muestra = BOTONES_ACTIVO_BAJO ? ~s2 : s2;

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      estable <= '0;
      for (int i = 0; i < 4; i++) contador[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (muestra[i] == estable[i]) begin
          contador[i] <= '0;
        end else if (contador[i] == FIN_ESTABLE) begin
          estable[i]  <= muestra[i];
          contador[i] <= '0;
        end else begin
          contador[i] <= contador[i] + 1'b1;
        end
      end
    end
  end

  // A key held across reset stays masked until seen released.
  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      llenado   <= '0;
      bloqueado <= '1;
    end else begin
      llenado <= {llenado[0], 1'b1};
      if (llenado[1])
        bloqueado <= bloqueado & (muestra | estable);
    end
  end

  assign efectivo  = estable & ~bloqueado;
  assign seleccion = efectivo & (~efectivo + 4'd1);

`ifdef AUTO_REPETICION_EN
  localparam logic [ANCHO_REPETICION-1:0] FIN_REP =
    ANCHO_REPETICION'(CICLOS_REPETICION - 1);

  logic [3:0] activo;
  logic [ANCHO_REPETICION-1:0] repeticion;
  logic activo_pulsado;
  logic rep_fin;

  assign activo_pulsado = |(estable & activo);
  assign rep_fin = (repeticion == FIN_REP);

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      activo     <= '0;
      repeticion <= '0;
    end else begin
      if (estado == LIBRE && efectivo != '0)
        activo <= seleccion;
      if (estado != ESPERA_SUELTA || !activo_pulsado || rep_fin)
        repeticion <= '0;
      else
        repeticion <= repeticion + 1'b1;
    end
  end
`endif

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      estado <= LIBRE;
      pulso  <= '0;
    end else begin
      estado <= estado_sig;
      pulso  <= pulso_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      LIBRE:
        if (efectivo != '0) estado_sig = ESPERA_SUELTA;
      ESPERA_SUELTA:
        if (estable == '0) estado_sig = LIBRE;
      default: estado_sig = LIBRE;
    endcase
  end

  always_comb begin
    pulso_sig = '0;
    unique case (estado)
      LIBRE:
        pulso_sig = seleccion;
      ESPERA_SUELTA: begin
`ifdef AUTO_REPETICION_EN
        if (rep_fin && activo_pulsado)
          pulso_sig = activo;
`endif
      end
      default: pulso_sig = '0;
    endcase
  end

  assign botones.botonArriba     = pulso[0];
  assign botones.botonAbajo      = pulso[1];
  assign botones.botonIzquierda  = pulso[2];
  assign botones.botonDerecha    = pulso[3];
  assign botones.botonesEstables = estable;

endmodule

// File: tb/tb_modulo_acondicionador_botones.sv
// Directed bench for the button conditioner, short debounce
// and repeat periods; follows AUTO_REPETICION_EN if defined.
module tb_modulo_acondicionador_botones;

  logic reloj;
  logic reinicio;
  int   pasados;
  int   total;
  int   n_arriba;
  int   n_abajo;
  int   n_izq;
  int   n_der;
  int   n_vistos;
  int   base;
  int   base_v;
  logic [3:0] pulsos;

`ifdef AUTO_REPETICION_EN
  localparam int PULSOS_40 = 4;
`else
  localparam int PULSOS_40 = 1;
`endif

  modulo_acondicionador_botones_if bus ();

  modulo_acondicionador_botones #(
    .CICLOS_ESTABLE      (4),
    .ANCHO_CONTADOR      (3),
    .BOTONES_ACTIVO_BAJO (1'b1),
    .CICLOS_REPETICION   (10),
    .ANCHO_REPETICION    (4)
  ) dut (
    .reloj    (reloj),
    .reinicio (reinicio),
    .botones  (bus)
  );

  assign pulsos = {bus.botonDerecha, bus.botonIzquierda,
                   bus.botonAbajo, bus.botonArriba};

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    n_arriba = 0;
    n_abajo  = 0;
    n_izq    = 0;
    n_der    = 0;
    n_vistos = 0;
    forever begin
      @(negedge reloj);
      if (pulsos[0]) n_arriba++;
      if (pulsos[1]) n_abajo++;
      if (pulsos[2]) n_izq++;
      if (pulsos[3]) n_der++;
      if (bus.botonesEstables != 4'b0000) n_vistos++;
    end
  end

  task automatic ciclo();
    @(posedge reloj);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    total++;
    assert (obs === exp) pasados++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  initial begin
    pasados = 0;
    total   = 0;
    reinicio = 1'b0;
    bus.botonArribaCrudo    = 1'b1;
    bus.botonAbajoCrudo     = 1'b1;
    bus.botonIzquierdaCrudo = 1'b1;
    bus.botonDerechaCrudo   = 1'b1;
    repeat (3) ciclo();
    chk("reset_estables", int'(bus.botonesEstables), 0);
    chk("reset_pulsos", int'(pulsos), 0);
    reinicio = 1'b1;
    repeat (5) ciclo();
    chk("reposo_estables", int'(bus.botonesEstables), 0);

    // clean press of arriba
    bus.botonArribaCrudo = 1'b0;
    repeat (5) ciclo();
    chk("limpio_c5", int'(bus.botonesEstables), 0);
    ciclo();
    chk("limpio_c6_est", int'(bus.botonesEstables), 1);
    chk("limpio_c6_pul", int'(pulsos), 0);
    ciclo();
    chk("limpio_c7_pul", int'(pulsos), 1);
    ciclo();
    chk("limpio_c8_pul", int'(pulsos), 0);
    repeat (12) ciclo();
    bus.botonArribaCrudo = 1'b1;
    repeat (10) ciclo();
    chk("limpio_cuenta", n_arriba, 1);
    chk("limpio_suelta", int'(bus.botonesEstables), 0);

    // 3-cycle glitch on abajo
    base_v = n_vistos;
    bus.botonAbajoCrudo = 1'b0;
    repeat (3) ciclo();
    bus.botonAbajoCrudo = 1'b1;
    repeat (10) ciclo();
    chk("glitch_estable", n_vistos - base_v, 0);
    chk("glitch_cuenta", n_abajo, 0);

    // bouncing derecha, then settles low
    base_v = n_vistos;
    for (int k = 0; k < 6; k++) begin
      bus.botonDerechaCrudo = (k % 2 == 1);
      repeat (2) ciclo();
    end
    bus.botonDerechaCrudo = 1'b0;
    chk("rebote_estable", n_vistos - base_v, 0);
    chk("rebote_sin_pulso", n_der, 0);
    repeat (5) ciclo();
    chk("rebote_c5", int'(bus.botonesEstables), 0);
    ciclo();
    chk("rebote_c6", int'(bus.botonesEstables), 8);
    ciclo();
    chk("rebote_c7_pul", int'(pulsos), 8);
    repeat (5) ciclo();
    chk("rebote_cuenta", n_der, 1);
    bus.botonDerechaCrudo = 1'b1;
    repeat (10) ciclo();

    // izquierda and abajo together
    bus.botonAbajoCrudo     = 1'b0;
    bus.botonIzquierdaCrudo = 1'b0;
    repeat (6) ciclo();
    chk("simul_est", int'(bus.botonesEstables), 6);
    ciclo();
    chk("simul_pul", int'(pulsos), 2);
    repeat (5) ciclo();
    bus.botonAbajoCrudo = 1'b1;
    repeat (10) ciclo();
    chk("simul_izq_sola", int'(bus.botonesEstables), 4);
    chk("simul_sin_izq", n_izq, 0);
    chk("simul_abajo", n_abajo, 1);
    bus.botonIzquierdaCrudo = 1'b1;
    repeat (10) ciclo();
    chk("simul_suelta", int'(bus.botonesEstables), 0);
    bus.botonIzquierdaCrudo = 1'b0;
    repeat (7) ciclo();
    chk("reizq_pul", int'(pulsos), 4);
    ciclo();
    chk("reizq_cuenta", n_izq, 1);
    bus.botonIzquierdaCrudo = 1'b1;
    repeat (10) ciclo();

    // arriba held 40 cycles
    base = n_arriba;
    bus.botonArribaCrudo = 1'b0;
    repeat (40) ciclo();
    bus.botonArribaCrudo = 1'b1;
    repeat (10) ciclo();
    chk("mantener_40", n_arriba - base, PULSOS_40);

    // async reset during the pulse, key held through it
    base = n_arriba;
    bus.botonArribaCrudo = 1'b0;
    repeat (7) ciclo();
    chk("rst_pulso_antes", int'(pulsos), 1);
    #2;
    reinicio = 1'b0;
    #1;
    chk("rst_pulso_async", int'(pulsos), 0);
    chk("rst_est_async", int'(bus.botonesEstables), 0);
    ciclo();
    reinicio = 1'b1;
    repeat (20) ciclo();
    chk("rst_sostenido_est", int'(bus.botonesEstables), 1);
    chk("rst_sostenido_cuenta", n_arriba - base, 0);
    bus.botonArribaCrudo = 1'b1;
    repeat (10) ciclo();
    bus.botonArribaCrudo = 1'b0;
    repeat (7) ciclo();
    chk("rst_represion_pul", int'(pulsos), 1);
    ciclo();
    chk("rst_represion_cuenta", n_arriba - base, 1);
    bus.botonArribaCrudo = 1'b1;
    repeat (10) ciclo();

    $display("%0d/%0d checks passed", pasados, total);
    $finish;
  end

endmodule
